// File: rtl/tmds_deserializer.sv
// tmds_deserializer: serial TMDS symbol aligner locking onto control tokens at 10-bit boundaries
module tmds_deserializer #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       resync,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       word_is_ctrl,
  output logic       locked,
  output logic       align_err
);
  localparam int TW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [9:0] shreg, nxt;
  logic [3:0] bitcnt, bitcnt_n;
  logic [TW-1:0] tcnt, tcnt_n, tinc;
  logic [MW-1:0] mcnt, mcnt_n, minc;
  logic tok_hit, bnd, ld, err_n;
  assign nxt = {serial_in, shreg[9:1]};
  assign tok_hit = nxt inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  assign bnd = bitcnt == 4'd9;
  assign tinc = (tcnt == TW'(LOCK_CNT)) ? tcnt : tcnt + 1'b1;
  assign minc = (mcnt == MW'(LOSS_CNT)) ? mcnt : mcnt + 1'b1;
  assign locked = state == LOCKED;
  always_comb begin
    state_n = state;
    bitcnt_n = bnd ? 4'd0 : bitcnt + 4'd1;
    tcnt_n = tcnt;
    mcnt_n = mcnt;
    ld = 1'b0;
    err_n = 1'b0;
    case (state)
      HUNT: if (tok_hit) begin
        state_n = VERIFY;
        bitcnt_n = 4'd0;
        tcnt_n = TW'(1);
      end
      VERIFY: if (bnd && tok_hit) begin
        tcnt_n = tinc;
        if (tinc == TW'(LOCK_CNT)) begin
          state_n = LOCKED;
          mcnt_n = '0;
          ld = 1'b1;
        end
      end else if (bnd || tok_hit) begin
        state_n = HUNT;
        tcnt_n = '0;
      end
      LOCKED: if (bnd) begin
        ld = 1'b1;
        mcnt_n = tok_hit ? '0 : mcnt;
      end else if (tok_hit) begin
        err_n = 1'b1;
        mcnt_n = minc;
        if (minc == MW'(LOSS_CNT)) begin
          state_n = HUNT;
          mcnt_n = '0;
          tcnt_n = '0;
        end
      end
      default: state_n = HUNT;
    endcase
    // resync wins over everything, including the edge that would complete lock
    if (resync) begin
      state_n = HUNT;
      bitcnt_n = 4'd0;
      tcnt_n = '0;
      mcnt_n = '0;
      ld = 1'b0;
      err_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      shreg <= '0;
      bitcnt <= '0;
      tcnt <= '0;
      mcnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
      word_is_ctrl <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= nxt;
      bitcnt <= bitcnt_n;
      tcnt <= tcnt_n;
      mcnt <= mcnt_n;
      word_valid <= ld;
      align_err <= err_n;
      if (ld) begin
        word <= nxt;
        word_is_ctrl <= tok_hit;
      end
    end
  end
endmodule

// File: tb/tb_tmds_deserializer.sv
// tb_tmds_deserializer: directed bench for lock, data, slip, verify failure, resync and async reset
module tb_tmds_deserializer;
  logic clk = 1'b0;
  logic rst_n, serial_in, resync;
  logic [9:0] word;
  logic word_valid, word_is_ctrl, locked, align_err;
  int checks = 0, errors = 0;
  int cyc = 0, last = 0, ecnt = 0;
  localparam logic [9:0] TOK = 10'h354;
  tmds_deserializer dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .resync(resync),
    .word(word), .word_valid(word_valid), .word_is_ctrl(word_is_ctrl),
    .locked(locked), .align_err(align_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b, input logic rs);
    serial_in = b;
    resync = rs;
    @(posedge clk);
    #1;
    resync = 1'b0;
  endtask
  task automatic send_sym(input logic [9:0] s, input logic rs_last);
    for (int i = 0; i < 10; i++) send_bit(s[i], rs_last && i == 9);
  endtask
  task automatic send_toks(input int n);
    for (int i = 0; i < n; i++) send_sym(TOK, 1'b0);
  endtask
  task automatic chk_word(input string tag, input logic [9:0] w, input logic c);
    chk({tag, "_wv"}, word_valid, 1);
    chk({tag, "_word"}, word, w);
    chk({tag, "_ctrl"}, word_is_ctrl, c);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (align_err) ecnt++;
    if (word_valid) chk("wv_locked", locked, 1);
    if (!locked) last = 0;
    else if (word_valid) begin
      if (last != 0) chk("wv_gap", cyc - last, 10);
      last = cyc;
    end
  end
  initial begin
    rst_n = 1'b0;
    serial_in = 1'b0;
    resync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_wv", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_ctrl", word_is_ctrl, 0);
    chk("rst_err", align_err, 0);
    rst_n = 1'b1;
    repeat (3) send_bit(1'b0, 1'b0);
    send_toks(3);
    chk("pre_lock", locked, 0);
    send_toks(1);
    chk("lock", locked, 1);
    chk_word("lock", TOK, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_toks(1);
      chk_word("tok", TOK, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      send_sym(10'h1F0 + 10'(i), 1'b0);
      chk_word("data", 10'h1F0 + 10'(i), 1'b0);
      chk("data_locked", locked, 1);
    end
    send_toks(1);
    chk_word("tok_after_data", TOK, 1'b1);
    send_bit(1'b0, 1'b0);
    send_toks(2);
    chk("slip_locked", locked, 1);
    send_toks(1);
    chk("slip_lost", locked, 0);
    chk("slip_err", align_err, 1);
    send_toks(3);
    chk("slip_verify", locked, 0);
    send_toks(1);
    chk("relock", locked, 1);
    chk_word("relock", TOK, 1'b1);
    chk("err_count", ecnt, 3);
    send_bit(1'b0, 1'b1);
    chk("resync_drop", locked, 0);
    send_toks(2);
    send_sym(10'h1F0, 1'b0);
    chk("verify_fail", locked, 0);
    send_toks(3);
    chk("verify_3", locked, 0);
    send_sym(TOK, 1'b1);
    chk("resync_lock_edge", locked, 0);
    send_toks(3);
    chk("resync_verify", locked, 0);
    send_toks(1);
    chk("resync_relock", locked, 1);
    for (int i = 0; i < 4; i++) send_bit(TOK[i], 1'b0);
    chk("pre_rst_word", word, TOK);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_word", word, 0);
    chk("arst_ctrl", word_is_ctrl, 0);
    chk("arst_wv", word_valid, 0);
    chk("arst_err", align_err, 0);
    serial_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) send_bit(1'b0, 1'b0);
    send_toks(3);
    chk("arst_verify", locked, 0);
    send_toks(1);
    chk("arst_relock", locked, 1);
    chk_word("arst_relock", TOK, 1'b1);
    chk("err_total", ecnt, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
